s247_gps_fix_filter: RTL and testbench

Conditions raw GPS fixes before they reach the geofence check in `s247_pathfinder_top`, which consumes the filtered latitude/longitude. Accepts Q16.16 fixes over a valid/ready handshake and outputs a 2^AVG_LOG2-sample moving average. Rejects single-fix position jumps and flags a stale GPS source.

---
 rtl/s247_pathfinder_pkg.sv | 6 +
 rtl/s247_fix_window.sv | 39 +++
 rtl/s247_gps_fix_filter.sv | 95 +++++++++
 tb/tb_s247_gps_fix_filter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s247_pathfinder_pkg.sv
// s247_pathfinder_pkg: shared types and defaults for the pathfinder GPS front end.
package s247_pathfinder_pkg;
    typedef logic signed [31:0] q16_16_t;
    typedef enum logic [1:0] {ACQUIRE, TRACK, STALE} gps_filt_state_e;
    localparam logic [31:0] GPS_MAX_JUMP = 32'h0001_0000;
endpackage

// File: rtl/s247_fix_window.sv
// s247_fix_window: per-axis circular averaging window with running sum.
module s247_fix_window #(
    parameter int DATA_WIDTH = 32,
    parameter int AVG_LOG2   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] avg
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW = DATA_WIDTH + AVG_LOG2;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AVG_LOG2-1:0]   ptr;
    logic [AVG_LOG2:0]     count;
    logic signed [SW-1:0]  sum;
    assign full  = count[AVG_LOG2];
    assign empty = ~|count;
    assign avg   = sum[SW-1:AVG_LOG2];
    // Flushed slots hold zero so the oldest entry can always be subtracted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr   <= '0;
            count <= '0;
            sum   <= '0;
        end else if (push) begin
            mem[ptr] <= din;
            ptr      <= ptr + 1'b1;
            count    <= full ? count : count + 1'b1;
            sum      <= sum - {{AVG_LOG2{mem[ptr][DATA_WIDTH-1]}}, mem[ptr]}
                            + {{AVG_LOG2{din[DATA_WIDTH-1]}}, din};
        end
    end
endmodule

// File: rtl/s247_gps_fix_filter.sv
// s247_gps_fix_filter: moving-average GPS fix filter with jump rejection and stale detection.
module s247_gps_fix_filter
    import s247_pathfinder_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    FRAC_BITS    = 16,
    parameter int                    AVG_LOG2     = 2,
    parameter logic [DATA_WIDTH-1:0] MAX_JUMP     = DATA_WIDTH'(GPS_MAX_JUMP),
    parameter int                    STALE_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fix_valid,
    output logic                  fix_ready,
    input  logic [DATA_WIDTH-1:0] fix_lat,
    input  logic [DATA_WIDTH-1:0] fix_lon,
    input  logic                  clear,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_lat,
    output logic [DATA_WIDTH-1:0] out_lon,
    output logic                  fix_locked,
    output logic                  fix_stale,
    output logic [15:0]           reject_cnt
);
    localparam int TW = $clog2(STALE_CYCLES + 1);
    if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_guard
        $error("FRAC_BITS must be smaller than DATA_WIDTH");
    end
    gps_filt_state_e state, nxt;
    logic pend, pend_rej, accept, push, rej, jump, stale_go, flush, emit;
    logic full, empty, lat_full, lon_full, lat_empty, lon_empty;
    logic [TW-1:0] timer;
    logic [DATA_WIDTH-1:0] avg_lat, avg_lon, alat, alon;
    logic signed [DATA_WIDTH:0] dlat, dlon;
    assign full  = lat_full & lon_full;
    assign empty = lat_empty & lon_empty;
    // Step magnitudes are taken one bit wider so opposite-sign extremes cannot wrap.
    assign dlat = $signed({fix_lat[DATA_WIDTH-1], fix_lat}) - $signed({out_lat[DATA_WIDTH-1], out_lat});
    assign dlon = $signed({fix_lon[DATA_WIDTH-1], fix_lon}) - $signed({out_lon[DATA_WIDTH-1], out_lon});
    assign alat = dlat[DATA_WIDTH] ? -dlat : dlat;
    assign alon = dlon[DATA_WIDTH] ? -dlon : dlon;
    assign jump = {1'b0, alat} > {1'b0, MAX_JUMP} || {1'b0, alon} > {1'b0, MAX_JUMP};
    s247_fix_window #(.DATA_WIDTH(DATA_WIDTH), .AVG_LOG2(AVG_LOG2)) u_lat (
        .clk, .rst_n, .push, .flush, .din(fix_lat), .full(lat_full), .empty(lat_empty), .avg(avg_lat)
    );
    s247_fix_window #(.DATA_WIDTH(DATA_WIDTH), .AVG_LOG2(AVG_LOG2)) u_lon (
        .clk, .rst_n, .push, .flush, .din(fix_lon), .full(lon_full), .empty(lon_empty), .avg(avg_lon)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACQUIRE;
        else        state <= nxt;
    end
    // Lock is taken the cycle after the filling fix, once the window reports full.
    always_comb begin
        nxt = clear                       ? ACQUIRE :
              stale_go                    ? STALE   :
              state == STALE && push      ? ACQUIRE :
              state == ACQUIRE && pend && full ? TRACK : state;
    end
    always_comb begin
        fix_ready = !pend;
        accept    = fix_valid && !pend && !clear;
        rej       = accept && state == TRACK && jump;
        push      = accept && !rej;
        stale_go  = !push && !empty && timer == TW'(STALE_CYCLES - 1);
        flush     = clear || stale_go;
        emit      = pend && !pend_rej && full;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            pend       <= 1'b0;
            pend_rej   <= 1'b0;
            out_valid  <= 1'b0;
            out_lat    <= '0;
            out_lon    <= '0;
            fix_locked <= 1'b0;
            fix_stale  <= 1'b0;
            reject_cnt <= '0;
            timer      <= '0;
        end else begin
            pend      <= accept;
            pend_rej  <= rej;
            out_valid <= emit;
            if (emit) begin
                out_lat <= avg_lat;
                out_lon <= avg_lon;
            end
            fix_locked <= stale_go ? 1'b0 : emit ? 1'b1 : fix_locked;
            fix_stale  <= stale_go ? 1'b1 : push ? 1'b0 : fix_stale;
            if (pend && pend_rej && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 1'b1;
            timer <= (push || stale_go) ? '0 :
                     (!empty && timer != TW'(STALE_CYCLES)) ? timer + 1'b1 : timer;
        end
    end
endmodule

// File: tb/tb_s247_gps_fix_filter.sv
// tb_s247_gps_fix_filter: randomized and directed checks against a queue-based averaging model.
module tb_s247_gps_fix_filter;
    localparam int MJ = 32'h0001_0000;
    logic clk = 1'b0, rst_n = 1'b0, fix_valid = 1'b0, clear = 1'b0;
    logic [31:0] fix_lat = '0, fix_lon = '0;
    logic fix_ready, out_valid, fix_locked, fix_stale;
    logic [31:0] out_lat, out_lon;
    logic [15:0] reject_cnt;
    int vectors = 0, miscompares = 0;
    int q_lat[$], q_lon[$];
    bit m_locked, m_stale;
    int m_out_lat, m_out_lon, m_rej;

    s247_gps_fix_filter #(.STALE_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .fix_valid(fix_valid), .fix_ready(fix_ready),
        .fix_lat(fix_lat), .fix_lon(fix_lon), .clear(clear), .out_valid(out_valid),
        .out_lat(out_lat), .out_lon(out_lon), .fix_locked(fix_locked),
        .fix_stale(fix_stale), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    wire [83:0] dut_vec = {out_valid, fix_locked, fix_stale, reject_cnt, fix_ready, out_lat, out_lon};

    function automatic logic [83:0] model_vec(bit emit);
        return {emit, m_locked, m_stale, m_rej[15:0], 1'b1, m_out_lat, m_out_lon};
    endfunction

    function automatic int qavg(int q[$]);
        longint s = 0;
        foreach (q[i]) s += q[i];
        return int'((s - (((s % 4) + 4) % 4)) / 4);
    endfunction

    function automatic longint mag(longint d);
        return d < 0 ? -d : d;
    endfunction

    task automatic model_reset();
        q_lat.delete(); q_lon.delete();
        m_locked = 0; m_stale = 0; m_out_lat = 0; m_out_lon = 0; m_rej = 0;
    endtask

    task automatic model_stale();
        q_lat.delete(); q_lon.delete();
        m_locked = 0; m_stale = 1;
    endtask

    task automatic model_fix(input int lat, input int lon, output bit emit);
        emit = 0;
        if (m_locked && (mag(longint'(lat) - m_out_lat) > MJ || mag(longint'(lon) - m_out_lon) > MJ)) begin
            if (m_rej < 65535) m_rej++;
            return;
        end
        m_stale = 0;
        q_lat.push_back(lat); q_lon.push_back(lon);
        if (q_lat.size() > 4) begin q_lat.pop_front(); q_lon.pop_front(); end
        if (q_lat.size() == 4) begin
            emit = 1; m_locked = 1;
            m_out_lat = qavg(q_lat); m_out_lon = qavg(q_lon);
        end
    endtask

    task automatic drive_fix(input int lat, input int lon, output logic rdy_k, output logic stale_k);
        int n = 0;
        while (!fix_ready && n < 20) begin @(posedge clk); #1; n++; end
        vectors++;
        if (fix_ready !== 1'b1) begin miscompares++; $display("FAIL ready_wait got %b want 1", fix_ready); end
        fix_valid = 1'b1; fix_lat = lat; fix_lon = lon;
        @(posedge clk); #1;
        fix_valid = 1'b0;
        rdy_k = fix_ready; stale_k = fix_stale;
        @(posedge clk); #1;
    endtask

    task automatic apply_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dut_vec !== model_vec(0)) begin miscompares++; $display("FAIL reset_held got %h want %h", dut_vec, model_vec(0)); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (dut_vec !== model_vec(0)) begin miscompares++; $display("FAIL reset_release got %h want %h", dut_vec, model_vec(0)); end
    endtask

    task automatic test_acquire_track();
        int lats[5] = '{32'h000A_0000, 32'h000A_4000, 32'h0009_C000, 32'h000A_0000, 32'h000B_0000};
        logic rk, sk;
        bit emit;
        apply_clear();
        foreach (lats[i]) begin
            model_fix(lats[i], 32'h0014_0000, emit);
            drive_fix(lats[i], 32'h0014_0000, rk, sk);
            vectors++;
            if (dut_vec !== model_vec(emit) || rk !== 1'b0)
                begin miscompares++; $display("FAIL acq_fix%0d got %h rdy_k=%b want %h rdy_k=0", i, dut_vec, rk, model_vec(emit)); end
            if (i == 3) begin
                vectors++;
                if (out_lat !== 32'h000A_0000) begin miscompares++; $display("FAIL acq_first_avg got %h want 000a0000", out_lat); end
            end
        end
        vectors++;
        if (out_lat !== 32'h000A_4000) begin miscompares++; $display("FAIL track_avg got %h want 000a4000", out_lat); end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL valid_pulse got %b want 0", out_valid); end
    endtask

    task automatic test_jump();
        int lats[7] = '{32'h000A_0000, 32'h000A_0000, 32'h000A_0000, 32'h000A_0000, 32'h000B_8000, 32'h000B_0000, 32'h000B_0000};
        int lons[7] = '{32'h0014_0000, 32'h0014_0000, 32'h0014_0000, 32'h0014_0000, 32'h0014_0000, 32'h0014_0000, 32'h0015_0001};
        logic rk, sk;
        bit emit;
        apply_clear();
        foreach (lats[i]) begin
            model_fix(lats[i], lons[i], emit);
            drive_fix(lats[i], lons[i], rk, sk);
            vectors++;
            if (dut_vec !== model_vec(emit) || rk !== 1'b0)
                begin miscompares++; $display("FAIL jump_fix%0d got %h rdy_k=%b want %h rdy_k=0", i, dut_vec, rk, model_vec(emit)); end
        end
        vectors++;
        if (reject_cnt !== 16'd2 || out_lat !== 32'h000A_4000)
            begin miscompares++; $display("FAIL jump_totals got rej=%0d lat=%h want rej=2 lat=000a4000", reject_cnt, out_lat); end
    endtask

    task automatic test_negative();
        int lats[4] = '{-1, -1, -1, -2};
        logic rk, sk;
        bit emit;
        apply_clear();
        foreach (lats[i]) begin
            model_fix(lats[i], -lats[i], emit);
            drive_fix(lats[i], -lats[i], rk, sk);
            vectors++;
            if (dut_vec !== model_vec(emit)) begin miscompares++; $display("FAIL neg_fix%0d got %h want %h", i, dut_vec, model_vec(emit)); end
        end
        vectors++;
        if (out_lat !== 32'hFFFF_FFFE || out_lon !== 32'h0000_0001)
            begin miscompares++; $display("FAIL neg_floor got lat=%h lon=%h want fffffffe 00000001", out_lat, out_lon); end
    endtask

    task automatic test_stale();
        logic rk, sk;
        bit emit;
        apply_clear();
        for (int i = 0; i < 4; i++) begin
            model_fix(32'h000A_0000 + i * 32'h1000, 32'h0014_0000, emit);
            drive_fix(32'h000A_0000 + i * 32'h1000, 32'h0014_0000, rk, sk);
        end
        vectors++;
        if (dut_vec !== model_vec(1)) begin miscompares++; $display("FAIL stale_lock got %h want %h", dut_vec, model_vec(1)); end
        repeat (14) @(posedge clk);
        #1;
        vectors++;
        if (fix_stale !== 1'b0 || fix_locked !== 1'b1) begin miscompares++; $display("FAIL stale_early got s=%b l=%b want s=0 l=1", fix_stale, fix_locked); end
        @(posedge clk); #1;
        model_stale();
        vectors++;
        if (dut_vec !== model_vec(0)) begin miscompares++; $display("FAIL stale_entry got %h want %h", dut_vec, model_vec(0)); end
        for (int i = 0; i < 4; i++) begin
            model_fix(32'h0003_0000 + i, 32'h0004_0000, emit);
            drive_fix(32'h0003_0000 + i, 32'h0004_0000, rk, sk);
            vectors++;
            if (dut_vec !== model_vec(emit) || sk !== 1'b0)
                begin miscompares++; $display("FAIL relock_fix%0d got %h stale_k=%b want %h stale_k=0", i, dut_vec, sk, model_vec(emit)); end
        end
    endtask

    task automatic test_clear_drop();
        logic rk, sk;
        bit emit;
        apply_clear();
        vectors++;
        if (dut_vec !== model_vec(0)) begin miscompares++; $display("FAIL clear_zero got %h want %h", dut_vec, model_vec(0)); end
        for (int i = 0; i < 2; i++) begin
            model_fix(32'h0001_0000, 32'h0002_0000, emit);
            drive_fix(32'h0001_0000, 32'h0002_0000, rk, sk);
        end
        fix_valid = 1'b1; clear = 1'b1; fix_lat = 32'h0050_0000; fix_lon = 32'h0060_0000;
        @(posedge clk); #1;
        fix_valid = 1'b0; clear = 1'b0;
        model_reset();
        vectors++;
        if (dut_vec !== model_vec(0)) begin miscompares++; $display("FAIL clear_drop got %h want %h", dut_vec, model_vec(0)); end
        for (int i = 0; i < 4; i++) begin
            model_fix(32'h0070_0000 + i * 4, 32'h0080_0000, emit);
            drive_fix(32'h0070_0000 + i * 4, 32'h0080_0000, rk, sk);
            vectors++;
            if (dut_vec !== model_vec(emit) || out_valid !== (i == 3))
                begin miscompares++; $display("FAIL clear_refill%0d got %h want %h", i, dut_vec, model_vec(emit)); end
        end
    endtask

    task automatic test_reset_mid();
        logic rk, sk;
        bit emit;
        apply_clear();
        for (int i = 0; i < 3; i++) begin
            model_fix(32'h0002_0000, 32'h0002_0000, emit);
            drive_fix(32'h0002_0000, 32'h0002_0000, rk, sk);
        end
        fix_valid = 1'b1;
        @(posedge clk); #1;
        fix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== model_vec(0)) begin miscompares++; $display("FAIL reset_mid got %h want %h", dut_vec, model_vec(0)); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (dut_vec !== model_vec(0)) begin miscompares++; $display("FAIL reset_after%0d got %h want %h", i, dut_vec, model_vec(0)); end
        end
    endtask

    function automatic int gen_step(bit big_ok);
        int p = int'($urandom_range(0, 9));
        if (!big_ok && p >= 2 && p <= 4) p = 9;
        case (p)
            0: return MJ;
            1: return -MJ;
            2: return MJ + 1;
            3: return -(MJ + 1);
            4: return int'($urandom_range(MJ + 1, 3 * MJ)) * ($urandom_range(0, 1) ? 1 : -1);
            default: return int'($urandom_range(0, 2 * MJ)) - MJ;
        endcase
    endfunction

    task automatic test_random();
        logic rk, sk;
        bit emit;
        int streak = 0, rej_before, lat, lon;
        apply_clear();
        for (int i = 0; i < 80; i++) begin
            lat = m_out_lat + gen_step(streak < 2);
            lon = m_out_lon + gen_step(streak < 2);
            rej_before = m_rej;
            model_fix(lat, lon, emit);
            streak = (m_rej != rej_before) ? streak + 1 : 0;
            drive_fix(lat, lon, rk, sk);
            vectors++;
            if (dut_vec !== model_vec(emit) || rk !== 1'b0)
                begin miscompares++; $display("FAIL rand_fix%0d got %h rdy_k=%b want %h rdy_k=0", i, dut_vec, rk, model_vec(emit)); end
            @(posedge clk); #1;
            vectors++;
            if (dut_vec !== model_vec(0)) begin miscompares++; $display("FAIL rand_idle%0d got %h want %h", i, dut_vec, model_vec(0)); end
            if ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_acquire_track();
        test_jump();
        test_negative();
        test_stale();
        test_clear_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
